stack_arbiter: RTL and testbench

//  Shares one stack instance between two requesters. Accepts NOP/PUSH/POP/GET requests over valid/ready,

---
 rtl/stack_arbiter_pkg.sv | 8 +
 rtl/stack_arbiter_if.sv | 15 +
 rtl/stack_arbiter_rr.sv | 14 +
 rtl/stack_arbiter.sv | 79 +++++++
 tb/tb_stack_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/stack_arbiter_pkg.sv
// stack_arbiter_pkg: shared types and default sizes for the two-client stack arbiter.
package stack_arbiter_pkg;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_IDX_W  = 3;
    localparam int DEF_DEPTH  = 5;
    typedef enum logic [1:0] {NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, GET = 2'b11} cmd_e;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_e;
endpackage

// File: rtl/stack_arbiter_if.sv
// stack_arbiter_if: two-client request/response bus; client i owns bit i / slice i of each field.
interface stack_arbiter_if #(parameter int DATA_W = 4, parameter int IDX_W = 3);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [3:0]          req_cmd;
    logic [2*IDX_W-1:0]  req_index;
    logic [2*DATA_W-1:0] req_data;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;
    modport master (output req_valid, req_cmd, req_index, req_data,
                    input  req_ready, rsp_valid, rsp_data, rsp_err);
    modport slave  (input  req_valid, req_cmd, req_index, req_data,
                    output req_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/stack_arbiter_rr.sv
// rr_arbiter_2: two-way round-robin; when both request, the client not granted last wins.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic fav;
    always_comb gnt = req[fav] ? (fav ? 2'b10 : 2'b01) : req[!fav] ? (fav ? 2'b01 : 2'b10) : 2'b00;
    always_ff @(posedge clk)
        if (reset) fav <= 1'b0;
        else if (advance && |gnt) fav <= gnt[0];
endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: shares one stack between two clients; accept -> issue -> capture -> respond,
// with occupancy tracking so illegal operations are answered with an error and never reach the stack.
module stack_arbiter
    import stack_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    stack_arbiter_if.slave    bus,
    output logic              stk_reset,
    output logic [1:0]        stk_command,
    output logic [IDX_W-1:0]  stk_index,
    output logic [DATA_W-1:0] stk_wdata,
    input  logic [DATA_W-1:0] stk_rdata,
    output logic [IDX_W:0]    count,
    output logic              busy
);
    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);
    state_e state, state_nx;
    cmd_e cmd_q, win_cmd;
    logic [IDX_W-1:0] idx_q, win_idx;
    logic [DATA_W-1:0] data_q, win_data;
    logic client_q, win_client, err_q, win_err, accept, active;
    logic [1:0] gnt, req_live;
    assign req_live = state == IDLE ? bus.req_valid : 2'b00;
    rr_arbiter_2 u_rr (.clk(clk), .reset(reset), .req(req_live), .advance(accept), .gnt(gnt));
    assign stk_reset = reset;
    assign bus.req_ready = accept ? gnt : 2'b00;
    always_comb begin
        accept     = !reset && |req_live;
        win_client = gnt[1];
        win_cmd    = cmd_e'(win_client ? bus.req_cmd[3:2] : bus.req_cmd[1:0]);
        win_idx    = win_client ? bus.req_index[2*IDX_W-1:IDX_W] : bus.req_index[IDX_W-1:0];
        win_data   = win_client ? bus.req_data[2*DATA_W-1:DATA_W] : bus.req_data[DATA_W-1:0];
        win_err    = (win_cmd == PUSH && count == FULL) || (win_cmd == POP && count == '0) ||
                     (win_cmd == GET && {1'b0, win_idx} >= count);
        state_nx   = state == IDLE ? (accept ? ISSUE : IDLE) : state == ISSUE ? CAPTURE : IDLE;
        active     = state == ISSUE && !reset && !err_q && cmd_q != NOP;
        stk_command = active ? cmd_q : NOP;
        stk_index  = active ? idx_q : '0;
        stk_wdata  = active ? data_q : '0;
        busy       = state != IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            cmd_q         <= NOP;
            idx_q         <= '0;
            data_q        <= '0;
            client_q      <= 1'b0;
            err_q         <= 1'b0;
            bus.rsp_valid <= 2'b00;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state         <= state_nx;
            bus.rsp_valid <= 2'b00;
            if (accept) begin
                cmd_q    <= win_cmd;
                idx_q    <= win_idx;
                data_q   <= win_data;
                client_q <= win_client;
                err_q    <= win_err;
            end
            if (active && cmd_q == PUSH) count <= count + 1'b1;
            else if (active && cmd_q == POP) count <= count - 1'b1;
            // Stack read data is valid in CAPTURE, one cycle after the POP/GET edge.
            if (state == CAPTURE) begin
                bus.rsp_valid <= client_q ? 2'b10 : 2'b01;
                bus.rsp_data  <= (!err_q && (cmd_q == POP || cmd_q == GET)) ? stk_rdata : '0;
                bus.rsp_err   <= err_q;
            end
        end
    end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed and random traffic from two clients against a queue-based reference model
// and a behavioural stack attached to the stack pins.
module tb_stack_arbiter;
    localparam int DW = 4, IW = 3, DEPTH = 5;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    stack_arbiter_if #(.DATA_W(DW), .IDX_W(IW)) bus ();
    logic stk_reset, busy;
    logic [1:0] stk_command;
    logic [IW-1:0] stk_index;
    logic [DW-1:0] stk_wdata, stk_rdata = '0;
    logic [IW:0] count;
    stack_arbiter #(.DATA_W(DW), .IDX_W(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus), .stk_reset(stk_reset), .stk_command(stk_command),
        .stk_index(stk_index), .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .count(count), .busy(busy));
    // Behavioural stack device: front of the queue is the top of stack.
    logic [DW-1:0] sq[$];
    always @(posedge clk)
        if (stk_reset) begin
            sq.delete();
            stk_rdata <= '0;
        end else case (stk_command)
            2'b01: sq.push_front(stk_wdata);
            2'b10: if (sq.size() > 0) stk_rdata <= sq.pop_front();
            2'b11: stk_rdata <= (int'(stk_index) < sq.size()) ? sq[stk_index] : '0;
            default: ;
        endcase
    typedef struct {logic [1:0] cmd; logic [IW-1:0] idx; logic [DW-1:0] data;} req_t;
    typedef struct {int cyc; logic [1:0] vld; logic [DW-1:0] data; logic err;} rsp_t;
    req_t cq0[$], cq1[$];
    rsp_t sb[$];
    logic [DW-1:0] mq[$];
    int tests = 0, fails = 0, cyc = 0, next_ok = 0, fav = 0;
    int exp_count = 0, pend_count = 0, pend_cyc = -1, cmd_cyc = -1;
    req_t cmd_req;
    logic [1:0] acc;
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    function automatic req_t mk(int c, int i, int d);
        req_t r;
        r.cmd = 2'(c);
        r.idx = IW'(i);
        r.data = DW'(d);
        return r;
    endfunction
    task automatic model_accept(int w, req_t r, logic [1:0] er);
        logic err;
        logic [DW-1:0] d;
        err = 1'b0;
        d = '0;
        case (r.cmd)
            2'b01: if (mq.size() == DEPTH) err = 1'b1; else mq.push_front(r.data);
            2'b10: if (mq.size() == 0) err = 1'b1; else d = mq.pop_front();
            2'b11: if (int'(r.idx) >= mq.size()) err = 1'b1; else d = mq[r.idx];
            default: ;
        endcase
        if (!err && r.cmd != 2'b00) begin
            cmd_cyc = cyc + 1;
            cmd_req = r;
        end
        pend_count = mq.size();
        pend_cyc = cyc + 2;
        sb.push_back('{cyc + 3, er, d, err});
        fav = 1 - w;
        next_ok = cyc + 3;
    endtask
    task automatic cycle();
        int w;
        logic [1:0] v, er;
        req_t r;
        bus.req_valid = {cq1.size() != 0, cq0.size() != 0};
        bus.req_cmd   = {cq1.size() != 0 ? cq1[0].cmd : 2'b00, cq0.size() != 0 ? cq0[0].cmd : 2'b00};
        bus.req_index = {cq1.size() != 0 ? cq1[0].idx : IW'(0), cq0.size() != 0 ? cq0[0].idx : IW'(0)};
        bus.req_data  = {cq1.size() != 0 ? cq1[0].data : DW'(0), cq0.size() != 0 ? cq0[0].data : DW'(0)};
        @(negedge clk);
        acc = 2'b00;
        if (reset) begin
            chk("ready_in_reset", bus.req_ready, 0);
            chk("stk_cmd_in_reset", stk_command, 0);
            chk("stk_reset", stk_reset, 1);
            mq.delete();
            sb.delete();
            exp_count = 0;
            pend_cyc = -1;
            cmd_cyc = -1;
            fav = 0;
            next_ok = cyc + 1;
        end else begin
            if (pend_cyc >= 0 && cyc >= pend_cyc) begin
                exp_count = pend_count;
                pend_cyc = -1;
            end
            chk("count", count, exp_count);
            chk("busy", busy, cyc < next_ok);
            chk("stk_cmd", stk_command, cyc == cmd_cyc ? cmd_req.cmd : 2'b00);
            if (cyc == cmd_cyc && cmd_req.cmd == 2'b11) chk("stk_index", stk_index, cmd_req.idx);
            if (cyc == cmd_cyc && cmd_req.cmd == 2'b01) chk("stk_wdata", stk_wdata, cmd_req.data);
            if (cyc != cmd_cyc) chk("stk_idle_pins", {stk_index, stk_wdata}, 0);
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                chk("rsp_valid", bus.rsp_valid, sb[0].vld);
                chk("rsp_data", bus.rsp_data, sb[0].data);
                chk("rsp_err", bus.rsp_err, sb[0].err);
                void'(sb.pop_front());
            end else chk("rsp_quiet", bus.rsp_valid, 0);
            v = bus.req_valid;
            w = -1;
            if (cyc >= next_ok && v != 2'b00) w = (v == 2'b11) ? fav : (v[1] ? 1 : 0);
            er = w < 0 ? 2'b00 : (w == 1 ? 2'b10 : 2'b01);
            chk("ready", bus.req_ready, er);
            acc = bus.req_ready;
            if (w >= 0) begin
                r = w == 1 ? cq1[0] : cq0[0];
                model_accept(w, r, er);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc[0]) void'(cq0.pop_front());
        if (acc[1]) void'(cq1.pop_front());
    endtask
    task automatic drain();
        int n;
        n = 0;
        while ((cq0.size() != 0 || cq1.size() != 0 || sb.size() != 0) && n < 400) begin
            cycle();
            n++;
        end
        chk("drain_timeout", n < 400, 1);
    endtask
    initial begin
        int n;
        bus.req_valid = '0;
        bus.req_cmd = '0;
        bus.req_index = '0;
        bus.req_data = '0;
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_count", count, 0);
        // Fill to capacity, then overflow.
        for (int i = 1; i <= 6; i++) cq0.push_back(mk(1, 0, i));
        drain();
        chk("full_count", count, DEPTH);
        // Peek every slot, then one past the top.
        for (int i = 0; i <= 5; i++) cq1.push_back(mk(3, i, 0));
        drain();
        // Empty it, then underflow.
        for (int i = 0; i < 6; i++) cq0.push_back(mk(2, 0, 0));
        drain();
        chk("empty_count", count, 0);
        // Both clients contend; grants must alternate.
        for (int i = 0; i < 4; i++) begin
            cq0.push_back(mk(1, 0, 8 + i));
            cq1.push_back(mk(1, 0, 12 + i));
        end
        drain();
        // Reset during the issue cycle of a POP.
        cq0.push_back(mk(2, 0, 0));
        n = 0;
        acc = 2'b00;
        while (acc == 2'b00 && n < 50) begin
            cycle();
            n++;
        end
        chk("pop_accept_timeout", n < 50, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cq0.push_back(mk(1, 0, 3));
        cq1.push_back(mk(1, 0, 9));
        drain();
        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            if (cq0.size() == 0 && $urandom_range(0, 2) == 0)
                cq0.push_back(mk($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 15)));
            if (cq1.size() == 0 && $urandom_range(0, 2) == 0)
                cq1.push_back(mk($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 15)));
            cycle();
        end
        drain();
        cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
